turbo_ce_gen: RTL and testbench

Parametrised clock-enable and CPU turbo controller for the Spectrum host board. It divides clk_sys into the fixed peripheral enables (28M, 7M phases, PSG) and the CPU p/n enables for LEVELS selectable speeds. It switches speed glitch-free by stalling the CPU for a pause window, and inserts SDRAM wait stalls at high speeds and during tape load. Sits between the HID/tape request logic and T80pa, wd1793, ym2149 and smart_tape.

---
 rtl/turbo_pkg.sv | 42 ++++
 rtl/turbo_ce_gen_ce_divider.sv | 57 +++++
 rtl/turbo_ce_gen.sv | 119 +++++++++++
 tb/tb_turbo_ce_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// turbo_pkg: shared definitions for the Spectrum clock-enable / CPU turbo
// controller.
//   LEVELS       - default number of turbo levels (0 = slowest)
//   LW           - width of a level number
//   level_e      - names of the default speed levels
//   ctrl_state_e - CPU run controller states
//   level_mask() - divider mask that selects the CPU enable period of a level
package turbo_pkg;

  localparam int LEVELS     = 5;
  localparam int MAX_LEVELS = 16;

  // Width of a level number; at least one bit even for a single level.
  function automatic int level_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

  localparam int LW = level_width(LEVELS);

  typedef enum logic [2:0] {
    LVL_3M5 = 3'd0,
    LVL_7M  = 3'd1,
    LVL_14M = 3'd2,
    LVL_28M = 3'd3,
    LVL_56M = 3'd4
  } level_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // CPU enabled
    ST_PAUSE = 2'd1,  // speed change in progress, pause counter running
    ST_STALL = 2'd2   // CPU held, waiting for the next tick with ram_ready
  } ctrl_state_e;

  // {levels{1'b1}} >> level: level 0 uses every divider bit (slowest CPU
  // enable), each higher level drops the top bit and doubles the rate.
  function automatic logic [MAX_LEVELS-1:0] level_mask(input int levels, input int level);
    logic [MAX_LEVELS-1:0] full;
    full = {MAX_LEVELS{1'b1}} >> (MAX_LEVELS - levels);
    return full >> level;
  endfunction

endpackage

// File: rtl/turbo_ce_gen_ce_divider.sv
// ce_divider: free-running master counter and the registered clock enables
// derived from it.
//   clk_sys, reset     - system clock, synchronous active-high reset
//   cur_level          - active turbo level, selects the tp/tn period
//   ce_28m             - every 4th clk_sys
//   ce_7mp / ce_7mn    - 7 MHz enables, half a period apart
//   ce_psg             - once per counter wrap
//   tp / tn            - turbo CPU p/n enables (tn half a period after tp)
module ce_divider
  import turbo_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int LEVELS = turbo_pkg::LEVELS,
  parameter int LW     = level_width(LEVELS)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [LW-1:0] cur_level,
  output logic          ce_28m,
  output logic          ce_7mp,
  output logic          ce_7mn,
  output logic          ce_psg,
  output logic          tp,
  output logic          tn
);

  logic [CNT_W-1:0]  counter;
  logic [LEVELS-1:0] mask;
  logic [LEVELS-1:0] cnt_lo;

  assign mask   = LEVELS'(level_mask(LEVELS, int'(cur_level)));
  assign cnt_lo = counter[LEVELS-1:0];

  // NOTE: state registers use non-blocking assignments so every flop in
  // this block samples the pre-edge counter value, regardless of order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      counter <= '0;
      ce_28m  <= 1'b0;
      ce_7mp  <= 1'b0;
      ce_7mn  <= 1'b0;
      ce_psg  <= 1'b0;
      tp      <= 1'b0;
      tn      <= 1'b0;
    end else begin
      counter <= counter + 1'b1;
      ce_28m  <= (counter[1:0] == 2'd0);
      ce_7mp  <= !counter[3] && (counter[2:0] == 3'd0);
      ce_7mn  <=  counter[3] && (counter[2:0] == 3'd0);
      ce_psg  <= (counter == '0);
      tp      <= ((cnt_lo & mask) == '0);
      // Masked count equal to the top mask bit alone: half a period after tp.
      tn      <= (((cnt_lo & mask) ^ mask ^ (mask >> 1)) == '0);
    end
  end

endmodule

// File: rtl/turbo_ce_gen.sv
// turbo_ce_gen: clock-enable generator and CPU turbo controller.
//   clk_sys, reset           - system clock, synchronous active-high reset
//   level_req, force_fast    - requested speed; force_fast selects the top level
//   ram_ready, tape_active   - SDRAM ready and tape playback, drive wait stalls
//   ula_ce_p, ula_ce_n       - contended CPU enables used at level 0
//   ce_28m, ce_7mp, ce_7mn, ce_psg - fixed peripheral enables
//   ce_cpu_p, ce_cpu_n       - gated CPU enables for T80pa
//   ce_cpu                   - turbo p-enable gated only by cpu_en (FDC, tape)
//   cpu_en, cur_level, switching - controller status
// Speed changes are glitch-free: the CPU is stopped on a cpu_n tick, the
// level changes, and the CPU restarts only after SWITCH_PAUSE further ticks.
module turbo_ce_gen
  import turbo_pkg::*;
#(
  parameter int CNT_W           = 6,
  parameter int LEVELS          = turbo_pkg::LEVELS,
  parameter int SWITCH_PAUSE    = 3,
  parameter int FAST_WAIT_LEVEL = 3,
  parameter int TAPE_WAIT_LEVEL = 2,
  parameter int LW              = level_width(LEVELS)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic [LW-1:0] level_req,
  input  logic          force_fast,
  input  logic          ram_ready,
  input  logic          tape_active,
  input  logic          ula_ce_p,
  input  logic          ula_ce_n,
  output logic          ce_28m,
  output logic          ce_7mp,
  output logic          ce_7mn,
  output logic          ce_psg,
  output logic          ce_cpu_p,
  output logic          ce_cpu_n,
  output logic          ce_cpu,
  output logic          cpu_en,
  output logic [LW-1:0] cur_level,
  output logic          switching
);

  localparam int          PW         = (SWITCH_PAUSE > 0) ? $clog2(SWITCH_PAUSE + 1) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'(SWITCH_PAUSE);
  localparam logic [LW-1:0] TOP_LEVEL  = LW'(LEVELS - 1);

  logic          tp;
  logic          tn;
  logic          cpu_p;
  logic          cpu_n;
  logic          wait_stall;
  logic [LW-1:0] req_eff;
  logic [PW-1:0] pause;
  ctrl_state_e   state;

  ce_divider #(
    .CNT_W  (CNT_W),
    .LEVELS (LEVELS),
    .LW     (LW)
  ) u_div (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cur_level (cur_level),
    .ce_28m    (ce_28m),
    .ce_7mp    (ce_7mp),
    .ce_7mn    (ce_7mn),
    .ce_psg    (ce_psg),
    .tp        (tp),
    .tn        (tn)
  );

  // Level 0 follows the ULA so contention timing is preserved.
  assign cpu_p = (cur_level == LW'(LVL_3M5)) ? ula_ce_p : tp;
  assign cpu_n = (cur_level == LW'(LVL_3M5)) ? ula_ce_n : tn;

  assign ce_cpu_p  = cpu_en & cpu_p;
  assign ce_cpu_n  = cpu_en & cpu_n;
  assign ce_cpu    = cpu_en & tp;
  assign switching = (pause != '0);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    req_eff = level_req;
    if (force_fast || (level_req > TOP_LEVEL)) req_eff = TOP_LEVEL;
  end

  assign wait_stall = !ram_ready &&
                      ((cur_level >= LW'(FAST_WAIT_LEVEL)) ||
                       ((cur_level >= LW'(TAPE_WAIT_LEVEL)) && tape_active));

  // Controller advances only on ungated cpu_n ticks, so a change of level
  // always lands between CPU half-cycles. The pause counter update comes
  // first and is overridden by a new switch; the branches see the old pause.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_RUN;
      cur_level <= LW'(LVL_3M5);
      cpu_en    <= 1'b1;
      pause     <= '0;
    end else if (cpu_n) begin
      if (pause != '0) pause <= (pause == PAUSE_LAST) ? '0 : pause + 1'b1;
      if ((state == ST_PAUSE) && (pause == PAUSE_LAST)) state <= ST_STALL;

      if (cur_level != req_eff) begin
        state     <= ST_PAUSE;
        cpu_en    <= 1'b0;
        pause     <= PW'(1);
        cur_level <= req_eff;
      end else if ((state == ST_STALL) && ram_ready) begin
        state  <= ST_RUN;
        cpu_en <= 1'b1;
      end else if (wait_stall) begin
        cpu_en <= 1'b0;
        if (state == ST_RUN) state <= ST_STALL;
      end
    end
  end

endmodule

// File: tb/tb_turbo_ce_gen.sv
module tb_turbo_ce_gen;

  localparam int CNT_W = 6;
  localparam int LEVELS = 5;
  localparam int SP = 3;
  localparam int FWL = 3;
  localparam int TWL = 2;
  localparam int LW = 3;
  localparam logic [11:0] RESET_VEC = 12'b0000_0001_0000;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic [LW-1:0] level_req = '0;
  logic force_fast = 1'b0, ram_ready = 1'b1, tape_active = 1'b0;
  logic ula_ce_p = 1'b0, ula_ce_n = 1'b0;
  logic ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en, switching;
  logic [LW-1:0] cur_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: counter value, enables, level, run flag, and the
  // number of cpu_n ticks seen since the last speed change (saturates at SP).
  int m_cnt = 0, m_level = 0, m_since = SP;
  bit m_28, m_7p, m_7n, m_psg, m_tp, m_tn;
  bit m_en = 1'b1;

  turbo_ce_gen #(
    .CNT_W(CNT_W), .LEVELS(LEVELS), .SWITCH_PAUSE(SP),
    .FAST_WAIT_LEVEL(FWL), .TAPE_WAIT_LEVEL(TWL), .LW(LW)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .level_req(level_req), .force_fast(force_fast),
    .ram_ready(ram_ready), .tape_active(tape_active), .ula_ce_p(ula_ce_p), .ula_ce_n(ula_ce_n),
    .ce_28m(ce_28m), .ce_7mp(ce_7mp), .ce_7mn(ce_7mn), .ce_psg(ce_psg),
    .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n), .ce_cpu(ce_cpu), .cpu_en(cpu_en),
    .cur_level(cur_level), .switching(switching)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_update();
    int period, req, old_level;
    bit cpu_n, pause_old;
    if (reset) begin
      m_cnt = 0; m_level = 0; m_en = 1'b1; m_since = SP;
      {m_28, m_7p, m_7n, m_psg, m_tp, m_tn} = '0;
      return;
    end
    old_level = m_level;
    cpu_n = (old_level == 0) ? ula_ce_n : m_tn;
    req = force_fast ? LEVELS - 1 : ((int'(level_req) > LEVELS - 1) ? LEVELS - 1 : int'(level_req));
    if (cpu_n) begin
      pause_old = (m_since < SP);
      if (m_since < SP) m_since++;
      if (req != m_level) begin
        m_en = 1'b0; m_level = req; m_since = 0;
      end else if (!m_en && !pause_old && ram_ready) m_en = 1'b1;
      else if (m_level >= FWL && !ram_ready) m_en = 1'b0;
      else if (m_level >= TWL && !ram_ready && tape_active) m_en = 1'b0;
    end
    period = 1 << (LEVELS - old_level);
    m_tp  = (m_cnt % period) == 0;
    m_tn  = (m_cnt % period) == period / 2;
    m_28  = (m_cnt % 4) == 0;
    m_7p  = (m_cnt % 16) == 0;
    m_7n  = (m_cnt % 16) == 8;
    m_psg = (m_cnt == 0);
    m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  function automatic logic [11:0] exp_vec();
    logic cp, cn;
    cp = (m_level == 0) ? ula_ce_p : m_tp;
    cn = (m_level == 0) ? ula_ce_n : m_tn;
    return {m_28, m_7p, m_7n, m_psg, m_en & cp, m_en & cn, m_en & m_tp, m_en,
            (m_since < SP), 3'(m_level)};
  endfunction

  function automatic logic [11:0] obs_vec();
    return {ce_28m, ce_7mp, ce_7mn, ce_psg, ce_cpu_p, ce_cpu_n, ce_cpu, cpu_en, switching, cur_level};
  endfunction

  // One clk_sys cycle: new ULA enables, edge, model update, sample at edge+1.
  task automatic step();
    if (reset) begin
      ula_ce_p = 1'b0; ula_ce_n = 1'b0;
    end else begin
      ula_ce_p = ($urandom_range(0, 4) == 0);
      ula_ce_n = ($urandom_range(0, 4) == 1);
    end
    @(posedge clk_sys);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (obs_vec() !== RESET_VEC) begin
        failures++; $display("FAIL reset_state cyc=%0d got=%b exp=%b", cyc, obs_vec(), RESET_VEC);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_base_rate();
    int last_p = -1, last_psg = -1, last_7p = -1;
    level_req = 3'd1; ram_ready = 1'b1;
    for (int i = 0; i < 328; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL base_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (i >= 200) begin
        checks++;
        if (cpu_en !== 1'b1 || cur_level !== 3'd1) begin
          failures++; $display("FAIL base_run cyc=%0d cpu_en=%b level=%0d exp 1/1", cyc, cpu_en, cur_level);
        end
        if (ce_cpu_p) begin
          if (last_p >= 0) begin
            checks++;
            if (cyc - last_p != 16) begin
              failures++; $display("FAIL base_cpu_period got=%0d exp=16", cyc - last_p);
            end
          end
          last_p = cyc;
        end
        if (ce_psg) begin
          if (last_psg >= 0) begin
            checks++;
            if (cyc - last_psg != 64) begin
              failures++; $display("FAIL base_psg_period got=%0d exp=64", cyc - last_psg);
            end
          end
          last_psg = cyc;
        end
        if (ce_7mp) last_7p = cyc;
        if (ce_7mn && last_7p >= 0) begin
          checks++;
          if (cyc - last_7p != 8) begin
            failures++; $display("FAIL base_7m_phase got=%0d exp=8", cyc - last_7p);
          end
        end
      end
    end
  endtask

  task automatic test_switch();
    int sw_cycles = 0, en_low = 0, last_p = -1;
    level_req = 3'd4;
    repeat (60) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL switch_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
      if (!cpu_en && (ce_cpu_p || ce_cpu_n)) begin
        failures++; $display("FAIL switch_gated cyc=%0d ce_cpu_p=%b ce_cpu_n=%b exp 0", cyc, ce_cpu_p, ce_cpu_n);
      end
      sw_cycles += int'(switching);
      en_low += int'(!cpu_en);
    end
    // Switch on a level-1 tick; level-4 ticks then come every 2 cycles,
    // the first one 3 cycles after the switch edge.
    checks++;
    if (sw_cycles != 7) begin
      failures++; $display("FAIL switch_pause_len got=%0d exp=7", sw_cycles);
    end
    checks++;
    if (en_low != 9) begin
      failures++; $display("FAIL switch_stall_len got=%0d exp=9", en_low);
    end
    repeat (20) begin
      step();
      if (ce_cpu_p) begin
        if (last_p >= 0) begin
          checks++;
          if (cyc - last_p != 2) begin
            failures++; $display("FAIL switch_fast_period got=%0d exp=2", cyc - last_p);
          end
        end
        last_p = cyc;
      end
    end
  endtask

  task automatic test_ram_wait();
    ram_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL ramwait_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({cpu_en, ce_cpu_p, ce_cpu_n} !== 3'b000) begin
      failures++; $display("FAIL ramwait_stalled got=%b exp=000", {cpu_en, ce_cpu_p, ce_cpu_n});
    end
    ram_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL ramwait_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (cpu_en !== 1'b1) begin
      failures++; $display("FAIL ramwait_resume got=%b exp=1", cpu_en);
    end
  endtask

  typedef struct { int lvl; bit tape; bit ram; int cycles; bit en_exp; } tape_row_t;

  task automatic test_tape_wait();
    tape_row_t rows[7];
    rows = '{'{2, 1'b0, 1'b1, 80, 1'b1}, '{2, 1'b1, 1'b0, 20, 1'b0}, '{2, 1'b1, 1'b1, 20, 1'b1},
             '{2, 1'b0, 1'b0, 20, 1'b1}, '{1, 1'b0, 1'b1, 100, 1'b1}, '{1, 1'b1, 1'b0, 40, 1'b1},
             '{1, 1'b0, 1'b1, 10, 1'b1}};
    foreach (rows[r]) begin
      level_req = 3'(rows[r].lvl); tape_active = rows[r].tape; ram_ready = rows[r].ram;
      repeat (rows[r].cycles) begin
        step();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++; $display("FAIL tape_model row=%0d cyc=%0d got=%b exp=%b", r, cyc, obs_vec(), exp_vec());
        end
      end
      checks++;
      if (cpu_en !== rows[r].en_exp || cur_level !== 3'(rows[r].lvl)) begin
        failures++; $display("FAIL tape_row%0d cpu_en=%b level=%0d exp %b/%0d",
                             r, cpu_en, cur_level, rows[r].en_exp, rows[r].lvl);
      end
    end
    tape_active = 1'b0; ram_ready = 1'b1;
  endtask

  task automatic test_force_fast();
    level_req = 3'd0; force_fast = 1'b1;
    repeat (80) begin
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL force_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (cur_level !== 3'd4 || cpu_en !== 1'b1) begin
      failures++; $display("FAIL force_level level=%0d cpu_en=%b exp 4/1", cur_level, cpu_en);
    end
    force_fast = 1'b0;
    repeat (100) step();
    checks++;
    if (cur_level !== 3'd0) begin
      failures++; $display("FAIL force_release level=%0d exp 0", cur_level);
    end
    repeat (60) begin
      step();
      checks++;
      if ({ce_cpu_p, ce_cpu_n} !== {ula_ce_p & m_en, ula_ce_n & m_en}) begin
        failures++; $display("FAIL ula_mirror cyc=%0d got=%b exp=%b", cyc, {ce_cpu_p, ce_cpu_n},
                             {ula_ce_p & m_en, ula_ce_n & m_en});
      end
    end
  endtask

  task automatic test_clamp_reset();
    int n = 0;
    level_req = 3'd7;
    while (switching !== 1'b1 && n < 200) begin
      step(); n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL clamp_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (switching !== 1'b1 || cur_level !== 3'd4) begin
      failures++; $display("FAIL clamp_level switching=%b level=%0d exp 1/4", switching, cur_level);
    end
    reset = 1'b1;
    step();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++; $display("FAIL reset_mid_switch got=%b exp=%b", obs_vec(), RESET_VEC);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({ce_psg, ce_28m, ce_7mp, cur_level} !== {3'b111, 3'd0}) begin
      failures++; $display("FAIL reset_counter_restart got=%b exp=111000", {ce_psg, ce_28m, ce_7mp, cur_level});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) level_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) force_fast = ~force_fast;
      if ($urandom_range(0, 49) == 0) tape_active = ~tape_active;
      ram_ready = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_base_rate();
    test_switch();
    test_ram_wait();
    test_tape_wait();
    test_force_fast();
    test_clamp_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
